// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA sync/blank/coordinate generator
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CNT_W      = 10,
  parameter int FC_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             sync_en,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             line_start,
  output logic             frame_start,
  output logic [FC_W-1:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last counter values; totals may equal 2^CNT_W, so the last value always fits.
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Decode thresholds carry one extra bit so a sync pulse ending at the total
  // does not truncate to zero.
  localparam logic [CNT_W:0] H_ACT_END = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] HS_START  = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END    = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_ACT_END = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] VS_START  = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END    = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hpos_q, hpos_d;
  logic [CNT_W-1:0] vpos_q, vpos_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic [CNT_W:0]   hpos_x, vpos_x;
  logic             h_in_sync, v_in_sync;

  // Next-state counters and strobes; level outputs decode the next counters so
  // they line up with the coordinates registered in the same edge.
  always_comb begin
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    fc_d    = fc_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (ce) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        line_d = 1'b1;
        if (vpos_q == V_LAST) begin
          vpos_d  = '0;
          frame_d = 1'b1;
          fc_d    = fc_q + 1'b1;
        end else begin
          vpos_d = vpos_q + 1'b1;
        end
      end else begin
        hpos_d = hpos_q + 1'b1;
      end
    end
    hpos_x    = {1'b0, hpos_d};
    vpos_x    = {1'b0, vpos_d};
    h_in_sync = (hpos_x >= HS_START) && (hpos_x < HS_END);
    v_in_sync = (vpos_x >= VS_START) && (vpos_x < VS_END);
    hsync_d   = (sync_en && h_in_sync) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d   = (sync_en && v_in_sync) ? V_SYNC_POL : ~V_SYNC_POL;
    de_d      = (hpos_x < H_ACT_END) && (vpos_x < V_ACT_END);
  end

  // State register; reset parks on the last pixel so the first enable enters (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q  <= H_LAST;
      vpos_q  <= V_LAST;
      fc_q    <= '0;
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      fc_q    <= fc_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_count = fc_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = de_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen (default and small geometry)
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst_a_n, ce_a, sen_a;
  logic       hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] hp_a, vp_a;
  logic [7:0] fc_a;

  logic       rst_b_n, ce_b, sen_b;
  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [2:0] hp_b, vp_b;
  logic [1:0] fc_b;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .rst_n(rst_a_n), .ce(ce_a), .sync_en(sen_a),
    .hsync(hs_a), .vsync(vs_a), .display_on(de_a), .hpos(hp_a), .vpos(vp_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CNT_W(3), .FC_W(2)
  ) u_b (
    .clk(clk), .rst_n(rst_b_n), .ce(ce_b), .sync_en(sen_b),
    .hsync(hs_b), .vsync(vs_b), .display_on(de_b), .hpos(hp_b), .vpos(vp_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int de_cnt, vs_cnt, hs_cnt, period, ls_cnt, bad;
  int prev_h, prev_v;

  initial begin
    rst_a_n = 1'b0; ce_a = 1'b1; sen_a = 1'b1;
    rst_b_n = 1'b0; ce_b = 1'b1; sen_b = 1'b1;
    tick(3);

    // Reset state, default geometry
    check("a_rst_hpos", hp_a, 799);
    check("a_rst_vpos", vp_a, 524);
    check("a_rst_hsync", hs_a, 1);
    check("a_rst_vsync", vs_a, 1);
    check("a_rst_de", de_a, 0);
    check("a_rst_ls", ls_a, 0);
    check("a_rst_fs", fs_a, 0);
    check("a_rst_fc", fc_a, 0);

    // First enable enters (0,0)
    rst_a_n = 1'b1;
    tick(1);
    check("a_c1_hpos", hp_a, 0);
    check("a_c1_vpos", vp_a, 0);
    check("a_c1_fs", fs_a, 1);
    check("a_c1_ls", ls_a, 1);
    check("a_c1_fc", fc_a, 1);
    check("a_c1_de", de_a, 1);
    tick(1);
    check("a_c2_ls", ls_a, 0);
    check("a_c2_fs", fs_a, 0);

    // Active/blank edge and hsync falling edge
    tick(638);
    check("a_h639_de", de_a, 1);
    tick(1);
    check("a_h640_de", de_a, 0);
    tick(15);
    check("a_h655_hpos", hp_a, 655);
    check("a_h655_hsync", hs_a, 1);
    tick(1);
    check("a_h656_hsync", hs_a, 0);

    // sync_en drop and restore inside the pulse
    tick(44);
    check("a_h700_hpos", hp_a, 700);
    sen_a = 1'b0;
    tick(1);
    check("a_dis_hsync", hs_a, 1);
    check("a_dis_hpos", hp_a, 701);
    tick(39);
    check("a_h740_hsync", hs_a, 1);
    check("a_h740_hpos", hp_a, 740);
    sen_a = 1'b1;
    tick(1);
    check("a_en_hsync", hs_a, 0);
    tick(10);
    check("a_h751_hsync", hs_a, 0);
    tick(1);
    check("a_h752_hsync", hs_a, 1);

    // Line wrap at cycle 801
    tick(47);
    check("a_h799_vpos", vp_a, 0);
    tick(1);
    check("a_l1_hpos", hp_a, 0);
    check("a_l1_vpos", vp_a, 1);
    check("a_l1_ls", ls_a, 1);
    check("a_l1_fs", fs_a, 0);
    check("a_l1_de", de_a, 1);

    // ce low: counters hold, strobes drop
    ce_a = 1'b0;
    tick(3);
    check("a_hold_hpos", hp_a, 0);
    check("a_hold_vpos", vp_a, 1);
    check("a_hold_ls", ls_a, 0);
    check("a_hold_de", de_a, 1);
    ce_a = 1'b1;

    // Asynchronous reset mid-line
    tick(300);
    check("a_pre_rst_hpos", hp_a, 300);
    rst_a_n = 1'b0;
    #1;
    check("a_arst_hpos", hp_a, 799);
    check("a_arst_vpos", vp_a, 524);
    check("a_arst_de", de_a, 0);
    check("a_arst_fc", fc_a, 0);
    tick(1);
    rst_a_n = 1'b1;
    tick(1);
    check("a_rel_fs", fs_a, 1);
    check("a_rel_fc", fc_a, 1);
    check("a_rel_hpos", hp_a, 0);

    // Small geometry: reset state, totals 8x6, CNT_W=3
    check("b_rst_hpos", hp_b, 7);
    check("b_rst_vpos", vp_b, 5);
    check("b_rst_hsync", hs_b, 0);
    check("b_rst_vsync", vs_b, 1);
    rst_b_n = 1'b1;
    tick(1);
    check("b_c1_fs", fs_b, 1);
    check("b_c1_fc", fc_b, 1);
    check("b_c1_hsync", hs_b, 0);
    de_cnt = 0; vs_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      if (de_b) de_cnt++;
      if (!vs_b) vs_cnt++;
      if (hs_b) hs_cnt++;
      if (i == 5) check("b_h5_hsync", hs_b, 1);
      if (i == 7) check("b_h7_hsync", hs_b, 0);
      tick(1);
    end
    check("b_de_clks", de_cnt, 12);
    check("b_vs_clks", vs_cnt, 8);
    check("b_hs_clks", hs_cnt, 12);
    check("b_f2_fs", fs_b, 1);
    check("b_f2_fc", fc_b, 2);
    tick(48);
    check("b_f3_fc", fc_b, 3);
    tick(48);
    check("b_f4_fs", fs_b, 1);
    check("b_f4_fc_wrap", fc_b, 0);

    // ce every 4th clk: frame period 192, strobes one clk wide, counters hold
    period = 0; ls_cnt = 0; bad = 0;
    prev_h = int'(hp_b); prev_v = int'(vp_b);
    for (int i = 1; i <= 400 && period == 0; i++) begin
      ce_b = ((i % 4) == 0);
      tick(1);
      if (!ce_b && (int'(hp_b) != prev_h || int'(vp_b) != prev_v)) bad++;
      if (!ce_b && (ls_b || fs_b)) bad++;
      if (ls_b) ls_cnt++;
      if (fs_b) period = i;
      prev_h = int'(hp_b); prev_v = int'(vp_b);
    end
    check("b_ce4_period", period, 192);
    check("b_ce4_lines", ls_cnt, 6);
    check("b_ce4_hold", bad, 0);
    check("b_ce4_fc", fc_b, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
